// File: rtl/imem_dmem_responder_pkg.sv
// Shared widths, request payload and arbiter state encoding for the IF/MEM memory responder.
package imem_dmem_responder_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] rmask;
        logic [MASK_W-1:0] wmask;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_D,
        SERVE_I
    } resp_arb_state_t;

endpackage

// File: rtl/imem_dmem_responder_if.sv
// Generic req/resp memory bus: requester drives the request, responder returns data and a resp pulse.
interface imem_dmem_responder_if
    import imem_dmem_responder_pkg::*;
();

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              resp;

    modport master (output req, addr, rmask, wmask, wdata, input rdata, resp);
    modport slave (input req, addr, rmask, wmask, wdata, output rdata, resp);
    // Read-only responder view, used for the instruction fetch port.
    modport rd_slave (input req, addr, rmask, output rdata, resp);

endinterface

// File: rtl/imem_dmem_responder_req_slot.sv
// Single-entry holding register for one outstanding request.
module imem_dmem_responder_req_slot
    import imem_dmem_responder_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     clear,
    input  mem_req_t din,
    output logic     full,
    output mem_req_t dout
);

    // Clear wins; a load into an occupied slot is dropped so the held request stays intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load && !full) begin
            full <= 1'b1;
            dout <= din;
        end
    end

endmodule

// File: rtl/imem_dmem_responder.sv
// Serialises IF-stage fetches and MEM-stage data accesses onto one backing memory port, D before I.
module imem_dmem_responder
    import imem_dmem_responder_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    imem_dmem_responder_if.rd_slave  imem,
    imem_dmem_responder_if.slave     dmem,
    imem_dmem_responder_if.master    mem
);

    resp_arb_state_t state;

    logic     i_full, d_full;
    logic     i_load, d_load;
    logic     i_clear, d_clear;
    mem_req_t i_in, d_in;
    mem_req_t i_held, d_held;
    mem_req_t i_pick, d_pick;

    // Incoming payloads; fetches never write.
    assign i_in = '{addr: imem.addr, rmask: imem.rmask, wmask: '0, wdata: '0};
    assign d_in = '{addr: dmem.addr, rmask: dmem.rmask, wmask: dmem.wmask, wdata: dmem.wdata};

    assign i_load  = imem.req && !i_full;
    assign d_load  = dmem.req && !d_full;
    assign i_clear = (state == SERVE_I) && mem.resp;
    assign d_clear = (state == SERVE_D) && mem.resp;

    // A request arriving this cycle is visible to arbitration straight from the port.
    assign i_pick = i_full ? i_held : i_in;
    assign d_pick = d_full ? d_held : d_in;

    imem_dmem_responder_req_slot u_i_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (i_load),
        .clear (i_clear),
        .din   (i_in),
        .full  (i_full),
        .dout  (i_held)
    );

    imem_dmem_responder_req_slot u_d_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (d_load),
        .clear (d_clear),
        .din   (d_in),
        .full  (d_full),
        .dout  (d_held)
    );

    // Arbiter FSM with registered backing request and pipeline responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem.req    <= 1'b0;
            mem.addr   <= '0;
            mem.rmask  <= '0;
            mem.wmask  <= '0;
            mem.wdata  <= '0;
            imem.resp  <= 1'b0;
            imem.rdata <= '0;
            dmem.resp  <= 1'b0;
            dmem.rdata <= '0;
        end else begin
            imem.resp <= 1'b0;
            dmem.resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_full || d_load) begin
                        state     <= SERVE_D;
                        mem.req   <= 1'b1;
                        mem.addr  <= d_pick.addr;
                        mem.rmask <= d_pick.rmask;
                        mem.wmask <= d_pick.wmask;
                        mem.wdata <= d_pick.wdata;
                    end else if (i_full || i_load) begin
                        state     <= SERVE_I;
                        mem.req   <= 1'b1;
                        mem.addr  <= i_pick.addr;
                        mem.rmask <= i_pick.rmask;
                        mem.wmask <= '0;
                        mem.wdata <= '0;
                    end
                end
                SERVE_D: begin
                    if (mem.resp) begin
                        state      <= IDLE;
                        mem.req    <= 1'b0;
                        dmem.rdata <= mem.rdata;
                        dmem.resp  <= 1'b1;
                    end
                end
                SERVE_I: begin
                    if (mem.resp) begin
                        state      <= IDLE;
                        mem.req    <= 1'b0;
                        imem.rdata <= mem.rdata;
                        imem.resp  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem.req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_imem_dmem_responder;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    imem_dmem_responder_if imem_bus ();
    imem_dmem_responder_if dmem_bus ();
    imem_dmem_responder_if mem_bus ();

    imem_dmem_responder dut (
        .clk  (clk),
        .rst  (rst),
        .imem (imem_bus),
        .dmem (dmem_bus),
        .mem  (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_bus.req = 0; imem_bus.addr = '0; imem_bus.rmask = '0;
        imem_bus.wmask = '0; imem_bus.wdata = '0;
        dmem_bus.req = 0; dmem_bus.addr = '0; dmem_bus.rmask = '0;
        dmem_bus.wmask = '0; dmem_bus.wdata = '0;
        mem_bus.resp = 0; mem_bus.rdata = '0;
    endtask

    task automatic test_reset();
        logic [147:0] outs;
        rst = 1;
        idle_inputs();
        mem_bus.resp = 1;
        cyc(); cyc();
        outs = {mem_bus.req, mem_bus.addr, mem_bus.rmask, mem_bus.wmask, mem_bus.wdata,
                imem_bus.resp, imem_bus.rdata, dmem_bus.resp, dmem_bus.rdata};
        vectors++;
        if (outs !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got %h exp 0", outs);
        end
        rst = 0;
        mem_bus.rdata = 32'hffffffff;
        cyc();
        mem_bus.resp = 0;
        vectors++;
        if (mem_bus.req !== 1'b0) begin
            miscompares++; $display("FAIL reset_stray_resp_req: got %b exp 0", mem_bus.req);
        end
        cyc();
        vectors++;
        if ({imem_bus.resp, dmem_bus.resp, imem_bus.rdata, dmem_bus.rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_stray_resp_out: got %b/%b %h/%h exp 0", imem_bus.resp,
                     dmem_bus.resp, imem_bus.rdata, dmem_bus.rdata);
        end
    endtask

    task automatic test_single_fetch();
        imem_bus.req = 1; imem_bus.addr = 32'h1eceb004; imem_bus.rmask = 4'hf;
        cyc();
        imem_bus.req = 0;
        vectors++;
        if ({mem_bus.req, mem_bus.addr, mem_bus.rmask, mem_bus.wmask, mem_bus.wdata}
            !== {1'b1, 32'h1eceb004, 4'hf, 4'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL fetch_issue: got req=%b addr=%h rm=%h wm=%h wd=%h exp 1 1eceb004 f 0 0",
                     mem_bus.req, mem_bus.addr, mem_bus.rmask, mem_bus.wmask, mem_bus.wdata);
        end
        cyc();
        mem_bus.resp = 1; mem_bus.rdata = 32'h00000013;
        cyc();
        mem_bus.resp = 0; mem_bus.rdata = 32'ha5a5a5a5;
        vectors++;
        if ({imem_bus.resp, imem_bus.rdata, dmem_bus.resp, mem_bus.req}
            !== {1'b1, 32'h00000013, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_resp: got iresp=%b idata=%h dresp=%b mreq=%b exp 1 00000013 0 0",
                     imem_bus.resp, imem_bus.rdata, dmem_bus.resp, mem_bus.req);
        end
        cyc();
        vectors++;
        if ({imem_bus.resp, imem_bus.rdata, dmem_bus.resp} !== {1'b0, 32'h00000013, 1'b0}) begin
            miscompares++;
            $display("FAIL fetch_hold: got iresp=%b idata=%h dresp=%b exp 0 00000013 0",
                     imem_bus.resp, imem_bus.rdata, dmem_bus.resp);
        end
    endtask

    task automatic test_contention();
        imem_bus.req = 1; imem_bus.addr = 32'h1eceb008; imem_bus.rmask = 4'hf;
        dmem_bus.req = 1; dmem_bus.addr = 32'h1eceb100; dmem_bus.rmask = 4'h0;
        dmem_bus.wmask = 4'hf; dmem_bus.wdata = 32'hdeadbeef;
        cyc();
        imem_bus.req = 0; dmem_bus.req = 0;
        vectors++;
        if ({mem_bus.req, mem_bus.addr, mem_bus.wmask, mem_bus.wdata}
            !== {1'b1, 32'h1eceb100, 4'hf, 32'hdeadbeef}) begin
            miscompares++;
            $display("FAIL contention_store_first: got req=%b addr=%h wm=%h wd=%h exp 1 1eceb100 f deadbeef",
                     mem_bus.req, mem_bus.addr, mem_bus.wmask, mem_bus.wdata);
        end
        mem_bus.resp = 1; mem_bus.rdata = 32'h11111111;
        cyc();
        mem_bus.resp = 0;
        vectors++;
        if ({dmem_bus.resp, dmem_bus.rdata, imem_bus.resp, mem_bus.req}
            !== {1'b1, 32'h11111111, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL contention_dresp: got dresp=%b ddata=%h iresp=%b mreq=%b exp 1 11111111 0 0",
                     dmem_bus.resp, dmem_bus.rdata, imem_bus.resp, mem_bus.req);
        end
        cyc();
        vectors++;
        if ({mem_bus.req, mem_bus.addr, mem_bus.wmask, mem_bus.wdata}
            !== {1'b1, 32'h1eceb008, 4'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL contention_fetch_second: got req=%b addr=%h wm=%h wd=%h exp 1 1eceb008 0 0",
                     mem_bus.req, mem_bus.addr, mem_bus.wmask, mem_bus.wdata);
        end
        mem_bus.resp = 1; mem_bus.rdata = 32'h22222222;
        cyc();
        mem_bus.resp = 0;
        vectors++;
        if ({imem_bus.resp, imem_bus.rdata, dmem_bus.resp} !== {1'b1, 32'h22222222, 1'b0}) begin
            miscompares++;
            $display("FAIL contention_iresp: got iresp=%b idata=%h dresp=%b exp 1 22222222 0",
                     imem_bus.resp, imem_bus.rdata, dmem_bus.resp);
        end
        cyc();
    endtask

    task automatic test_variable_latency();
        int resp_count;
        resp_count = 0;
        imem_bus.req = 1; imem_bus.addr = 32'h1eceb010; imem_bus.rmask = 4'h3;
        cyc();
        imem_bus.req = 0;
        for (int k = 0; k < 10; k++) begin
            mem_bus.rdata = $urandom;
            vectors++;
            if ({mem_bus.req, mem_bus.addr, mem_bus.rmask} !== {1'b1, 32'h1eceb010, 4'h3}) begin
                miscompares++;
                $display("FAIL latency_stable_%0d: got req=%b addr=%h rm=%h exp 1 1eceb010 3",
                         k, mem_bus.req, mem_bus.addr, mem_bus.rmask);
            end
            cyc();
        end
        mem_bus.resp = 1; mem_bus.rdata = 32'hcafe0001;
        cyc();
        mem_bus.resp = 0;
        for (int k = 0; k < 4; k++) begin
            if (imem_bus.resp === 1'b1) resp_count++;
            cyc();
        end
        vectors++;
        if (resp_count != 1 || imem_bus.rdata !== 32'hcafe0001) begin
            miscompares++;
            $display("FAIL latency_one_resp: got count=%0d data=%h exp 1 cafe0001",
                     resp_count, imem_bus.rdata);
        end
    endtask

    task automatic test_no_preempt();
        imem_bus.req = 1; imem_bus.addr = 32'h1eceb020; imem_bus.rmask = 4'hf;
        cyc();
        imem_bus.req = 0;
        cyc();
        dmem_bus.req = 1; dmem_bus.addr = 32'h1eceb200; dmem_bus.rmask = 4'h3;
        dmem_bus.wmask = 4'h0; dmem_bus.wdata = 32'h0;
        cyc();
        dmem_bus.req = 0;
        vectors++;
        if ({mem_bus.req, mem_bus.addr} !== {1'b1, 32'h1eceb020}) begin
            miscompares++;
            $display("FAIL preempt_keep_i: got req=%b addr=%h exp 1 1eceb020", mem_bus.req, mem_bus.addr);
        end
        mem_bus.resp = 1; mem_bus.rdata = 32'h0badf00d;
        cyc();
        mem_bus.resp = 0;
        vectors++;
        if ({imem_bus.resp, imem_bus.rdata, dmem_bus.resp, mem_bus.req}
            !== {1'b1, 32'h0badf00d, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL preempt_i_done: got iresp=%b idata=%h dresp=%b mreq=%b exp 1 0badf00d 0 0",
                     imem_bus.resp, imem_bus.rdata, dmem_bus.resp, mem_bus.req);
        end
        cyc();
        vectors++;
        if ({mem_bus.req, mem_bus.addr, mem_bus.rmask, mem_bus.wmask}
            !== {1'b1, 32'h1eceb200, 4'h3, 4'h0}) begin
            miscompares++;
            $display("FAIL preempt_d_next: got req=%b addr=%h rm=%h wm=%h exp 1 1eceb200 3 0",
                     mem_bus.req, mem_bus.addr, mem_bus.rmask, mem_bus.wmask);
        end
        mem_bus.resp = 1; mem_bus.rdata = 32'h12345678;
        cyc();
        mem_bus.resp = 0;
        vectors++;
        if ({dmem_bus.resp, dmem_bus.rdata, imem_bus.resp} !== {1'b1, 32'h12345678, 1'b0}) begin
            miscompares++;
            $display("FAIL preempt_d_done: got dresp=%b ddata=%h iresp=%b exp 1 12345678 0",
                     dmem_bus.resp, dmem_bus.rdata, imem_bus.resp);
        end
        cyc();
        vectors++;
        if ({dmem_bus.resp, imem_bus.resp, mem_bus.req} !== 3'b000) begin
            miscompares++;
            $display("FAIL preempt_quiet: got dresp=%b iresp=%b mreq=%b exp 0 0 0",
                     dmem_bus.resp, imem_bus.resp, mem_bus.req);
        end
    endtask

    task automatic test_reset_mid();
        logic [147:0] outs;
        dmem_bus.req = 1; dmem_bus.addr = 32'h1eceb300; dmem_bus.rmask = 4'hf;
        dmem_bus.wmask = 4'h0; dmem_bus.wdata = 32'h0;
        cyc();
        dmem_bus.req = 0;
        vectors++;
        if (mem_bus.req !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_serving: got req=%b exp 1", mem_bus.req);
        end
        rst = 1;
        cyc();
        rst = 0;
        outs = {mem_bus.req, mem_bus.addr, mem_bus.rmask, mem_bus.wmask, mem_bus.wdata,
                imem_bus.resp, imem_bus.rdata, dmem_bus.resp, dmem_bus.rdata};
        vectors++;
        if (outs !== '0) begin
            miscompares++; $display("FAIL rstmid_outputs: got %h exp 0", outs);
        end
        mem_bus.resp = 1; mem_bus.rdata = 32'h77777777;
        cyc();
        mem_bus.resp = 0;
        cyc();
        vectors++;
        if ({dmem_bus.resp, dmem_bus.rdata, mem_bus.req} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_late_resp: got dresp=%b ddata=%h mreq=%b exp 0 0 0",
                     dmem_bus.resp, dmem_bus.rdata, mem_bus.req);
        end
    endtask

    task automatic test_duplicate();
        int resp_count;
        resp_count = 0;
        imem_bus.req = 1; imem_bus.addr = 32'h1eceb004; imem_bus.rmask = 4'hf;
        cyc();
        imem_bus.addr = 32'h1eceb00c;
        cyc();
        imem_bus.req = 0;
        vectors++;
        if ({mem_bus.req, mem_bus.addr} !== {1'b1, 32'h1eceb004}) begin
            miscompares++;
            $display("FAIL dup_first_addr: got req=%b addr=%h exp 1 1eceb004", mem_bus.req, mem_bus.addr);
        end
        mem_bus.resp = 1; mem_bus.rdata = 32'h00000093;
        cyc();
        mem_bus.resp = 0;
        for (int k = 0; k < 4; k++) begin
            if (imem_bus.resp === 1'b1) resp_count++;
            vectors++;
            if (mem_bus.req !== 1'b0) begin
                miscompares++;
                $display("FAIL dup_no_reissue_%0d: got req=%b addr=%h exp 0", k, mem_bus.req, mem_bus.addr);
            end
            cyc();
        end
        vectors++;
        if (resp_count != 1) begin
            miscompares++; $display("FAIL dup_one_resp: got %0d exp 1", resp_count);
        end
    endtask

    task automatic test_back_to_back();
        imem_bus.req = 1; imem_bus.addr = 32'h1eceb040; imem_bus.rmask = 4'hf;
        cyc();
        imem_bus.req = 0;
        mem_bus.resp = 1; mem_bus.rdata = 32'h00000001;
        cyc();
        mem_bus.resp = 0;
        // New fetch in the response cycle must be accepted.
        imem_bus.req = 1; imem_bus.addr = 32'h1eceb044;
        vectors++;
        if (imem_bus.resp !== 1'b1) begin
            miscompares++; $display("FAIL b2b_first_resp: got %b exp 1", imem_bus.resp);
        end
        cyc();
        imem_bus.req = 0;
        vectors++;
        if ({mem_bus.req, mem_bus.addr} !== {1'b1, 32'h1eceb044}) begin
            miscompares++;
            $display("FAIL b2b_second_issue: got req=%b addr=%h exp 1 1eceb044", mem_bus.req, mem_bus.addr);
        end
        mem_bus.resp = 1; mem_bus.rdata = 32'h00000002;
        cyc();
        mem_bus.resp = 0;
        vectors++;
        if ({imem_bus.resp, imem_bus.rdata} !== {1'b1, 32'h00000002}) begin
            miscompares++;
            $display("FAIL b2b_second_resp: got %b %h exp 1 00000002", imem_bus.resp, imem_bus.rdata);
        end
        cyc();
    endtask

    // Random traffic: model keeps one pending request per port and the in-flight backing transaction.
    task automatic test_random(input int n);
        bit          d_pend, i_pend, exp_i, exp_d, i_known, d_known, sent;
        logic [31:0] da, dw, ia, last_i, last_d;
        logic [3:0]  drm, dwm, irm;
        int          svc, wc, stall;
        logic [71:0] exp_fields;
        d_pend = 0; i_pend = 0; exp_i = 0; exp_d = 0; i_known = 0; d_known = 0; sent = 0;
        da = 0; dw = 0; ia = 0; last_i = 0; last_d = 0; drm = 0; dwm = 0; irm = 0;
        svc = 0; wc = 0; stall = 0;
        for (int c = 0; c < n + 300; c++) begin
            cyc();
            vectors++;
            if (imem_bus.resp !== exp_i || (i_known && imem_bus.rdata !== last_i)) begin
                miscompares++;
                $display("FAIL rand_iresp c%0d: got %b %h exp %b %h", c, imem_bus.resp,
                         imem_bus.rdata, exp_i, last_i);
            end
            vectors++;
            if (dmem_bus.resp !== exp_d || (d_known && dmem_bus.rdata !== last_d)) begin
                miscompares++;
                $display("FAIL rand_dresp c%0d: got %b %h exp %b %h", c, dmem_bus.resp,
                         dmem_bus.rdata, exp_d, last_d);
            end
            if (exp_i) begin i_pend = 0; i_known = 1; end
            if (exp_d) begin d_pend = 0; d_known = 1; end
            exp_i = 0; exp_d = 0;

            if (svc != 0 && sent) begin
                vectors++;
                if (mem_bus.req !== 1'b0) begin
                    miscompares++; $display("FAIL rand_req_drop c%0d: got %b exp 0", c, mem_bus.req);
                end
                svc = 0; sent = 0;
            end else if (svc == 0) begin
                if (mem_bus.req === 1'b1) begin
                    vectors++;
                    if (d_pend) svc = 1;
                    else if (i_pend) svc = 2;
                    else begin
                        miscompares++; $display("FAIL rand_spurious_req c%0d: got 1 exp 0", c);
                    end
                    wc = $urandom_range(0, 4);
                    stall = 0;
                end else if (d_pend || i_pend) begin
                    stall++;
                    if (stall > 2) begin
                        vectors++; miscompares++; stall = 0;
                        $display("FAIL rand_stall c%0d: got req=0 exp 1", c);
                    end
                end
            end else begin
                vectors++;
                if (mem_bus.req !== 1'b1) begin
                    miscompares++; $display("FAIL rand_req_hold c%0d: got %b exp 1", c, mem_bus.req);
                end
            end
            if (svc != 0) begin
                exp_fields = (svc == 1) ? {da, drm, dwm, dw} : {ia, irm, 4'h0, 32'h0};
                vectors++;
                if ({mem_bus.addr, mem_bus.rmask, mem_bus.wmask, mem_bus.wdata} !== exp_fields) begin
                    miscompares++;
                    $display("FAIL rand_fields c%0d port%0d: got %h exp %h", c, svc,
                             {mem_bus.addr, mem_bus.rmask, mem_bus.wmask, mem_bus.wdata}, exp_fields);
                end
            end

            mem_bus.resp = 0;
            mem_bus.rdata = $urandom;
            if (svc != 0 && !sent) begin
                if (wc == 0) begin
                    mem_bus.resp = 1;
                    sent = 1;
                    if (svc == 1) begin exp_d = 1; last_d = mem_bus.rdata; end
                    else begin exp_i = 1; last_i = mem_bus.rdata; end
                end else begin
                    wc--;
                end
            end else if (svc == 0 && $urandom_range(0, 7) == 0) begin
                mem_bus.resp = 1;
            end

            imem_bus.req = 0; dmem_bus.req = 0;
            if (c < n) begin
                if ($urandom_range(0, 3) == 0) begin
                    imem_bus.req = 1; imem_bus.addr = $urandom; imem_bus.rmask = 4'($urandom);
                    if (!i_pend) begin i_pend = 1; ia = imem_bus.addr; irm = imem_bus.rmask; end
                end
                if ($urandom_range(0, 3) == 0) begin
                    dmem_bus.req = 1; dmem_bus.addr = $urandom; dmem_bus.rmask = 4'($urandom);
                    dmem_bus.wmask = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    dmem_bus.wdata = $urandom;
                    if (!d_pend) begin
                        d_pend = 1; da = dmem_bus.addr; drm = dmem_bus.rmask;
                        dwm = dmem_bus.wmask; dw = dmem_bus.wdata;
                    end
                end
            end else if (!d_pend && !i_pend && svc == 0 && !exp_i && !exp_d) begin
                break;
            end
        end
        vectors++;
        if (d_pend || i_pend || svc != 0) begin
            miscompares++;
            $display("FAIL rand_drain: got pending d=%b i=%b svc=%0d exp none", d_pend, i_pend, svc);
        end
        idle_inputs();
        cyc();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_variable_latency();
        test_no_preempt();
        test_reset_mid();
        test_duplicate();
        test_back_to_back();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
